// File: rtl/ch375_rxfifo.sv
// Receive byte FIFO between the CH375B serial driver and the CPU peripheral bus.
// Captures strobed bytes, exposes a small register window and raises a one-cycle irq.
module ch375_rxfifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_COUNT  = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_THR    = 3'd3;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [CW-1:0]         thr;
    logic                  ovf;
    logic                  ovf_nxt;
    logic                  irq_nxt;

    logic empty;
    logic full;
    logic wr_pop;
    logic wr_ctl;
    logic wr_thr;
    logic flush;
    logic clr_ovf;
    logic pop_ok;
    logic push_ok;
    logic drop;
    logic thr_hit;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // register write decode
    assign wr_pop  = we && (a == A_COUNT);
    assign wr_ctl  = we && (a == A_STATUS);
    assign wr_thr  = we && (a == A_THR);
    assign flush   = wr_ctl && d[25];
    assign clr_ovf = wr_ctl && d[24];

    // a pop on a full FIFO frees the slot the same-cycle push lands in
    assign pop_ok  = wr_pop && !empty && !flush;
    assign push_ok = rx_valid && !flush && (!full || pop_ok);
    assign drop    = rx_valid && !flush && full && !pop_ok;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push_ok && !pop_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_comb begin
        ovf_nxt = ovf;
        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt = 1'b0;
        end
    end

    // only an upward crossing caused by a net push counts as reaching the threshold
    assign thr_hit = push_ok && !pop_ok && (thr != '0) &&
                     (count_nxt == thr) && (count != thr);
    assign irq_nxt = thr_hit || (ovf_nxt && !ovf);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            thr   <= CNT_ONE;
            irq   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
            irq   <= irq_nxt;
            if (flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push_ok) wp <= wp + PTR_ONE;
                if (pop_ok)  rp <= rp + PTR_ONE;
            end
            if (wr_thr) thr <= d[24 +: CW];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= rx_data;
    end

    always_comb begin
        spo = '0;
        case (a)
            A_DATA:   spo[31:24] = empty ? 8'h00 : mem[rp];
            A_COUNT:  spo[31:24] = 8'(count);
            A_STATUS: spo[31:24] = {5'b0, ovf, full, empty};
            A_THR:    spo[31:24] = 8'(thr);
            default:  spo = '0;
        endcase
    end

endmodule

// File: tb/tb_ch375_rxfifo.sv
// Scoreboard bench for ch375_rxfifo: pushed bytes queue up and are compared as they pop,
// with a queue-based model predicting count, flags and the irq pulse every cycle.
module tb_ch375_rxfifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        irq;

    ch375_rxfifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .a(a), .d(d), .we(we), .spo(spo), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned sb[$];
    bit           m_ovf;
    int           m_thr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic peek_state(input string tag);
        logic [7:0] hd;
        a = 3'd1; #1;
        check({tag, "_count"}, spo, {8'(sb.size()), 24'h0});
        a = 3'd2; #1;
        check({tag, "_status"}, spo, {5'b0, m_ovf, sb.size() == 16, sb.size() == 0, 24'h0});
        hd = (sb.size() == 0) ? 8'h00 : sb[0];
        a = 3'd0; #1;
        check({tag, "_head"}, spo, {hd, 24'h0});
    endtask

    // one clock: drive stimulus, advance the model, check irq and visible state
    task automatic cycle(input bit v, input logic [7:0] b, input bit w,
                         input logic [2:0] wa, input logic [31:0] wd, input string tag);
        int  sz;
        bit  fl, cl, pp, acc, old_ovf, exp_irq;
        sz      = sb.size();
        fl      = w && wa == 3'd2 && wd[25];
        cl      = w && wa == 3'd2 && wd[24];
        pp      = w && wa == 3'd1 && sz > 0 && !fl;
        old_ovf = m_ovf;
        exp_irq = 1'b0;
        rx_valid = v; rx_data = b; we = w; a = wa; d = wd;
        if (fl) begin
            sb.delete();
            if (cl) m_ovf = 1'b0;
        end else begin
            acc = v && (sz < 16 || pp);
            if (pp) void'(sb.pop_front());
            if (acc) sb.push_back(b);
            if (v && !acc) m_ovf = 1'b1;
            else if (cl) m_ovf = 1'b0;
            exp_irq = (m_ovf && !old_ovf) ||
                      (acc && !pp && m_thr != 0 && sb.size() == m_thr && sz != m_thr);
        end
        if (w && wa == 3'd3) m_thr = int'(wd[28:24]);
        @(posedge clk); #1;
        rx_valid = 1'b0; we = 1'b0; d = '0;
        check({tag, "_irq"}, {31'b0, irq}, {31'b0, exp_irq});
        peek_state(tag);
    endtask

    task automatic push(input logic [7:0] b, input string tag);
        cycle(1'b1, b, 1'b0, 3'd0, 32'h0, tag);
    endtask

    task automatic pop(input string tag);
        a = 3'd0; #1;
        if (sb.size() > 0) check({tag, "_pop_data"}, spo, {sb[0], 24'h0});
        cycle(1'b0, 8'h00, 1'b1, 3'd1, 32'h0, tag);
    endtask

    task automatic set_thr(input int t);
        cycle(1'b0, 8'h00, 1'b1, 3'd3, {3'b0, 5'(t), 24'h0}, "thr_wr");
        a = 3'd3; #1;
        check("thr_rd", spo, {8'(t), 24'h0});
    endtask

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_data = '0; we = 1'b0; a = '0; d = '0;
        m_ovf = 1'b0; m_thr = 1;
        #12;
        check("rst_irq", {31'b0, irq}, 32'h0);
        a = 3'd2; #1; check("rst_status", spo, 32'h0100_0000);
        a = 3'd3; #1; check("rst_thr", spo, 32'h0100_0000);
        a = 3'd5; #1; check("rd_unmapped", spo, 32'h0);
        @(negedge clk); rst = 1'b1;

        // single byte with default threshold 1
        push(8'hA5, "single");
        pop("single");

        // burst of 16 with threshold 8, then a second pass to wrap the pointers
        set_thr(8);
        for (int i = 0; i < 16; i++) push(8'(i), "burst1");
        for (int i = 0; i < 16; i++) pop("drain1");
        for (int i = 16; i < 32; i++) push(8'(i), "burst2");
        for (int i = 0; i < 16; i++) pop("drain2");

        // overflow on a full FIFO, then clear
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i), "fill_ovf");
        push(8'hEE, "ovf_push");
        push(8'hEF, "ovf_again");
        cycle(1'b0, 8'h00, 1'b1, 3'd2, 32'h0100_0000, "ovf_clr");

        // full FIFO with push and pop on the same edge
        cycle(1'b1, 8'h77, 1'b1, 3'd1, 32'h0, "full_pushpop");
        for (int i = 0; i < 16; i++) pop("drain_pp");
        pop("pop_empty");

        // pop ignored when empty but same-cycle push accepted
        cycle(1'b1, 8'h3C, 1'b1, 3'd1, 32'h0, "empty_pushpop");
        pop("drain_ep");

        // flush coinciding with a received byte
        for (int i = 0; i < 3; i++) push(8'(8'h90 + i), "pre_flush");
        cycle(1'b1, 8'h55, 1'b1, 3'd2, 32'h0200_0000, "flush");
        cycle(1'b0, 8'h00, 1'b0, 3'd0, 32'h0, "post_flush");

        // threshold disabled
        set_thr(0);
        for (int i = 0; i < 3; i++) push(8'(8'hB0 + i), "thr0");
        cycle(1'b0, 8'h00, 1'b1, 3'd2, 32'h0200_0000, "flush2");

        // asynchronous reset mid-burst
        set_thr(3);
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), "pre_rst");
        @(negedge clk); #2;
        rst = 1'b0;
        sb.delete(); m_ovf = 1'b0; m_thr = 1;
        #1;
        peek_state("async_rst");
        a = 3'd3; #1; check("async_rst_thr", spo, 32'h0100_0000);
        rx_valid = 1'b1; rx_data = 8'hDD;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("rst_strobe_irq", {31'b0, irq}, 32'h0);
        peek_state("rst_strobe");
        @(negedge clk); rst = 1'b1;
        push(8'h12, "after_rst");
        pop("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
